// File: rtl/m0_alu_pkg.sv
// m0_alu_pkg: shared types and constants for the m0_alu_seq ALU.
//   alu_op_e : 4-bit operation codes (14 and 15 are reserved)
//   FLAG_*   : bit positions of N, Z, C, V inside a 4-bit NZCV vector
//   state_e  : sequencer states (IDLE / MUL / DONE)
package m0_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ADC = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_ORR = 4'd5,
        OP_EOR = 4'd6,
        OP_BIC = 4'd7,
        OP_MVN = 4'd8,
        OP_LSL = 4'd9,
        OP_LSR = 4'd10,
        OP_ASR = 4'd11,
        OP_ROR = 4'd12,
        OP_MUL = 4'd13
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/m0_alu_mul_iter.sv
// m0_alu_mul_iter: iterative shift-add multiplier, low WIDTH bits of a*b.
// Consumes MUL_STEP multiplier bits per cycle, WIDTH/MUL_STEP cycles total.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load a_i/b_i and begin (ignored bits of history are cleared)
//   a_i, b_i   : multiplicand, multiplier
//   done_o     : high in the cycle whose closing edge performs the last step
//   product_o  : final product, valid while done_o is high
//   cnt_o      : current step counter
module m0_alu_mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o,
    output logic [((WIDTH/MUL_STEP) > 1 ? $clog2(WIDTH/MUL_STEP) : 1)-1:0] cnt_o
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] partial_d;

    // Sum of the shifted multiplicand copies selected by this step's multiplier bits.
    always_comb begin
        partial_d = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (b_q[j]) partial_d = partial_d + (a_q << j);
        end
    end

    // The product is taken combinationally on the last step so the caller can
    // register it on the same edge that retires the multiply.
    assign product_o = acc_q + partial_d;
    assign done_o    = busy_q && (cnt_q == LAST);
    assign cnt_o     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= product_o;
            a_q   <= a_q << MUL_STEP;
            b_q   <= b_q >> MUL_STEP;
            if (cnt_q == LAST) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/m0_alu_seq.sv
// m0_alu_seq: handshaked Cortex-M0 data-processing ALU with NZCV flags.
// Single-cycle ops are registered once; MUL uses m0_alu_mul_iter.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (op, operand1, operand2, flags_in)
//   out_valid/out_ready : result handshake (result, flags_out)
//   dbg_state           : current sequencer state (state_e encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
module m0_alu_seq
    import m0_alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = ((WIDTH / MUL_STEP) > 1) ? $clog2(WIDTH / MUL_STEP) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;
    logic [1:0]       mul_cv_q;

    logic             accept, is_mul, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [CNT_W-1:0] mul_cnt;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags_out = flags_q;
    assign dbg_state = state_q;

    // ---------------- combinational single-cycle datapath ----------------
    logic [7:0]       amt;
    logic [WIDTH-1:0] addend;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [31:0]      rot_amt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, keep_flags;
    logic [3:0]       alu_flags;

    always_comb begin
        amt        = operand2[7:0];
        addend     = operand2;
        cin        = 1'b0;
        alu_res    = '0;
        alu_c      = flags_in[FLAG_C];
        alu_v      = flags_in[FLAG_V];
        keep_flags = 1'b0;
        rot_amt    = {24'd0, amt} % 32'(WIDTH);

        // Subtraction is op1 + ~op2 + cin, so ARM's "C = no borrow" falls out.
        case (op)
            OP_SUB:  begin addend = ~operand2; cin = 1'b1; end
            OP_ADC:  cin = flags_in[FLAG_C];
            OP_SBC:  begin addend = ~operand2; cin = flags_in[FLAG_C]; end
            default: ;
        endcase
        sum = {1'b0, operand1} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (operand1[WIDTH-1] == addend[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_AND: alu_res = operand1 & operand2;
            OP_ORR: alu_res = operand1 | operand2;
            OP_EOR: alu_res = operand1 ^ operand2;
            OP_BIC: alu_res = operand1 & ~operand2;
            OP_MVN: alu_res = ~operand2;
            OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
                if (amt == 8'd0) begin
                    alu_res = operand1;
                end else begin
                    // An extra bit beside the value catches the last bit shifted
                    // out; at amt == WIDTH it is the far-end bit, beyond it zero
                    // (or the sign for ASR).
                    case (op)
                        OP_LSL:  {alu_c, alu_res} = {1'b0, operand1} << amt;
                        OP_LSR:  {alu_res, alu_c} = {operand1, 1'b0} >> amt;
                        OP_ASR:  {alu_res, alu_c} = $signed({operand1, 1'b0}) >>> amt;
                        default: begin
                            alu_res = (operand1 >> rot_amt) |
                                      (operand1 << (32'(WIDTH) - rot_amt));
                            alu_c   = alu_res[WIDTH-1];
                        end
                    endcase
                end
            end
            OP_MUL:  ;
            default: keep_flags = 1'b1;
        endcase

        alu_flags          = flags_in;
        if (!keep_flags) begin
            alu_flags[FLAG_N] = alu_res[WIDTH-1];
            alu_flags[FLAG_Z] = (alu_res == '0);
            alu_flags[FLAG_C] = alu_c;
            alu_flags[FLAG_V] = alu_v;
        end
    end

    m0_alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept && is_mul),
        .a_i       (operand1),
        .b_i       (operand2),
        .done_o    (mul_done),
        .product_o (mul_product),
        .cnt_o     (mul_cnt)
    );

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            mul_cv_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_DONE && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (is_mul) begin
                            state_q     <= ST_MUL;
                            out_valid_q <= 1'b0;
                            mul_cv_q    <= flags_in[FLAG_C:FLAG_V];
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            flags_q     <= alu_flags;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_product;
                        flags_q     <= {mul_product[WIDTH-1], (mul_product == '0), mul_cv_q};
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Step counter lives in the multiplier; it is only observed there.
    logic unused_cnt;
    assign unused_cnt = ^mul_cnt;

endmodule

// File: tb/tb_m0_alu_seq.sv
// tb_m0_alu_seq: directed and random checks of m0_alu_seq against a
// behavioural model; a second instance covers MUL_STEP = 4.
module tb_m0_alu_seq;

    localparam int W       = 32;
    localparam int MUL_LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]    op, flags_in, flags_out;
    logic [W-1:0]  operand1, operand2, result;
    logic [1:0]    dbg_state;

    logic          in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]    flags_out4;
    logic [W-1:0]  result4;
    logic [1:0]    dbg_state4;

    int vectors     = 0;
    int miscompares = 0;
    logic [35:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    m0_alu_seq #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operand1(operand1), .operand2(operand2), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags_out(flags_out), .dbg_state(dbg_state)
    );

    m0_alu_seq #(.WIDTH(W), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op),
        .operand1(operand1), .operand2(operand2), .flags_in(flags_in),
        .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
        .flags_out(flags_out4), .dbg_state(dbg_state4)
    );

    // ---------------- reference model ----------------
    function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] f);
        logic [31:0] r, bb;
        logic c, v, ci;
        int amt, k;
        longint unsigned us;
        longint ss;
        c = f[1]; v = f[0]; r = 32'd0; amt = int'(b[7:0]);
        if (o <= 4'd3) begin
            bb = (o == 4'd1 || o == 4'd3) ? ~b : b;
            ci = (o == 4'd0) ? 1'b0 : (o == 4'd1) ? 1'b1 : f[1];
            us = {32'd0, a} + {32'd0, bb} + {63'd0, ci};
            r  = us[31:0];
            c  = us[32];
            ss = longint'($signed(a)) + longint'($signed(bb)) + longint'(ci);
            v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end else begin
            case (o)
                4'd4:  r = a & b;
                4'd5:  r = a | b;
                4'd6:  r = a ^ b;
                4'd7:  r = a & ~b;
                4'd8:  r = ~b;
                4'd9:  if (amt == 0) r = a;
                       else if (amt < 32) begin r = a << amt; c = a[32-amt]; end
                       else if (amt == 32) begin r = 0; c = a[0]; end
                       else begin r = 0; c = 1'b0; end
                4'd10: if (amt == 0) r = a;
                       else if (amt < 32) begin r = a >> amt; c = a[amt-1]; end
                       else if (amt == 32) begin r = 0; c = a[31]; end
                       else begin r = 0; c = 1'b0; end
                4'd11: if (amt == 0) r = a;
                       else if (amt < 32) begin r = $signed(a) >>> amt; c = a[amt-1]; end
                       else begin r = {32{a[31]}}; c = a[31]; end
                4'd12: begin
                    k = amt % 32;
                    if (amt == 0) r = a;
                    else if (k == 0) begin r = a; c = a[31]; end
                    else begin r = (a >> k) | (a << (32 - k)); c = r[31]; end
                end
                4'd13: begin us = {32'd0, a} * {32'd0, b}; r = us[31:0]; end
                default: return {f, 32'd0};
            endcase
        end
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] f, input logic [31:0] er, input logic [3:0] ef,
                          input string tag);
        int guard, lat;
        bit ready_low;
        op = o; operand1 = a; operand2 = b; flags_in = f; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin tick; guard++; end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        // Scramble inputs: the accepted request must already be latched.
        op = 4'($urandom); operand1 = $urandom; operand2 = $urandom; flags_in = 4'($urandom);
        lat = 1; ready_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_low = 1'b0;
            tick;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), (o == 4'd13) ? 32'(MUL_LAT) : 32'd1);
        check({tag, "_res"}, result, er);
        check({tag, "_flags"}, 32'(flags_out), 32'(ef));
        if (o == 4'd13) check({tag, "_busy"}, 32'(ready_low), 32'd1);
    endtask

    task automatic run_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] f, input string tag);
        logic [35:0] e;
        e = model(o, a, b, f);
        run_op(o, a, b, f, e[31:0], e[35:32], tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  o, f;
        logic [31:0] a, b, held_res;
        logic [3:0]  held_flags;
        logic [35:0] e;
        int lat;
        bit never_valid, stable;

        rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
        op = 4'd0; operand1 = '0; operand2 = '0; flags_in = 4'd0;
        tick; tick;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'(flags_out), 32'd0);
        rst = 1'b0;
        tick;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with hand-derived results.
        run_op(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 32'h0000_0000, 4'b0110, "add_wrap");
        run_op(4'd1,  32'h8000_0000, 32'h0000_0001, 4'b0000, 32'h7FFF_FFFF, 4'b0011, "sub_ovf");
        run_op(4'd3,  32'd5,         32'd3,         4'b0000, 32'd1,         4'b0010, "sbc");
        run_op(4'd9,  32'h8000_0001, 32'd32,        4'b0000, 32'h0000_0000, 4'b0110, "lsl32");
        run_op(4'd10, 32'h8000_0001, 32'd33,        4'b0000, 32'h0000_0000, 4'b0100, "lsr33");
        run_op(4'd11, 32'h8000_0001, 32'd40,        4'b0000, 32'hFFFF_FFFF, 4'b1010, "asr40");
        run_op(4'd12, 32'h8000_0001, 32'd32,        4'b0000, 32'h8000_0001, 4'b1010, "ror32");
        for (int s = 9; s <= 12; s++)
            run_op(4'(s), 32'h8000_0001, 32'h0000_0F00, 4'b0010, 32'h8000_0001, 4'b1010, "shift0");
        run_op(4'd4,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0011, 32'h0000_0000, 4'b0111, "and_pass");
        run_op(4'd14, 32'd5,         32'd6,         4'b1010, 32'h0000_0000, 4'b1010, "reserved");
        run_op(4'd13, 32'h0001_0001, 32'h0001_0001, 4'b0011, 32'h0002_0001, 4'b0011, "mul");

        // MUL with four bits per step on the second instance.
        op = 4'd13; operand1 = 32'h0001_0001; operand2 = 32'h0001_0001; flags_in = 4'b0000;
        in_valid4 = 1'b1;
        check("mul4_ready", 32'(in_ready4), 32'd1);
        tick;
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 100) begin tick; lat++; end
        check("mul4_lat", 32'(lat), 32'd9);
        check("mul4_res", result4, 32'h0002_0001);

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            o = 4'($urandom_range(0, 12)); a = $urandom; b = $urandom; f = 4'($urandom);
            exp_q.push_back(model(o, a, b, f));
            op = o; operand1 = a; operand2 = b; flags_in = f; in_valid = 1'b1;
            check("b2b_ready", 32'(in_ready), 32'd1);
            tick;
            e = exp_q.pop_front();
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_res", result, e[31:0]);
            check("b2b_flags", 32'(flags_out), 32'(e[35:32]));
        end
        in_valid = 1'b0;
        tick;

        // Backpressure: result held, no second accept until out_ready.
        out_ready = 1'b0;
        op = 4'd0; operand1 = 32'd7; operand2 = 32'd8; flags_in = 4'b0000; in_valid = 1'b1;
        tick;
        held_res = result; held_flags = flags_out;
        check("bp_first", result, 32'd15);
        op = 4'd1; operand1 = 32'd9; operand2 = 32'd4; flags_in = 4'b1111;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || in_ready || result !== held_res || flags_out !== held_flags)
                stable = 1'b0;
            tick;
        end
        check("bp_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        e = model(4'd1, 32'd9, 32'd4, 4'b1111);
        check("bp_second_res", result, 32'd5);
        check("bp_second_flags", 32'(flags_out), 32'(e[35:32]));
        tick;

        // Reset in the middle of a MUL.
        op = 4'd13; operand1 = 32'h1234_5678; operand2 = 32'h9ABC_DEF0; in_valid = 1'b1;
        check("rstmul_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstmul_valid", 32'(out_valid), 32'd0);
        check("rstmul_ready_after", 32'(in_ready), 32'd1);
        never_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) never_valid = 1'b0;
            tick;
        end
        check("rstmul_no_result", 32'(never_valid), 32'd1);
        run_op(4'd0, 32'd2, 32'd3, 4'b0000, 32'd5, 4'b0000, "add_after_rst");

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; f = 4'($urandom);
            if (o >= 4'd9 && o <= 4'd12 && $urandom_range(0, 3) != 0)
                b[7:0] = 8'($urandom_range(0, 40));
            run_model(o, a, b, f, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
